popcount_seq: RTL

Sequential, parametrised bit-population counter. It takes one WIDTH-bit word through a valid/ready handshake and counts CHUNK bits per clock. It returns the count through a valid/ready result handshake.
A mode input selects counting of ones or zeros. The block is the multi-cycle, area-reduced successor to the combinational ones counter, for datapaths that are too wide for a single-cycle adder tree.

---
 rtl/popcount_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/popcount_seq.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_seq
//  Description : Multi-cycle bit-population counter. Accepts one WIDTH-bit
//                word over a valid/ready handshake, counts CHUNK bits per
//                clock (ones, or zeros when in_mode = 1), and returns the
//                count over a valid/ready result handshake.
//                Optional macro POPCNT_ACCUM_EN adds a saturating running
//                total of results (acc_clr / acc_total).
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_seq #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
`ifdef POPCNT_ACCUM_EN
  ,
  parameter int ACC_W = 24
`endif
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+1)-1:0]   out_count
`ifdef POPCNT_ACCUM_EN
  ,
  input  logic                         acc_clr,
  output logic [ACC_W-1:0]             acc_total
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int NB = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  // Beat counter needs at least one bit even when the word fits in one beat.
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [BW-1:0] c_LAST_BEAT = BW'(NB - 1);

  // Reject parameter sets that would leave a partial final beat.
  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("popcount_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [CW-1:0]     r_sum;
  logic [CW-1:0]     r_count;
  logic [BW-1:0]     r_beat;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [CW-1:0]     w_chunk_pop;
  logic [CW-1:0]     w_sum_next;
  logic              w_res_hs;

  // Population count of the low CHUNK bits of the shift register.
  always_comb begin
    w_chunk_pop = '0;
    for (int i = 0; i < CHUNK; i++) begin
      w_chunk_pop = w_chunk_pop + CW'(r_shift[i]);
    end
    w_sum_next = r_sum + w_chunk_pop;
  end

  assign w_res_hs = r_out_valid & out_ready;

  // Control FSM with shift/accumulate datapath; all handshake outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_beat      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            // Zero counting is folded into ones counting by inverting here.
            r_shift    <= in_mode ? ~in_data : in_data;
            r_sum      <= '0;
            r_beat     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_COUNT;
          end
        end
        S_COUNT: begin
          r_sum   <= w_sum_next;
          r_shift <= r_shift >> CHUNK;
          r_beat  <= r_beat + BW'(1);
          if (r_beat == c_LAST_BEAT) begin
            r_count     <= w_sum_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          // out_count is left holding the last result after the handshake.
          if (w_res_hs) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_count;

`ifdef POPCNT_ACCUM_EN
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] w_acc_base;
  logic [ACC_W:0]   w_acc_sum;

  // Next running total: optional clear, then add the result being handed off.
  always_comb begin
    w_acc_base = acc_clr ? '0 : r_acc;
    w_acc_sum  = {1'b0, w_acc_base} + {{(ACC_W + 1 - CW){1'b0}}, r_count};
  end

  // Saturating accumulator of delivered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_res_hs) begin
      r_acc <= w_acc_sum[ACC_W] ? '1 : w_acc_sum[ACC_W-1:0];
    end else if (acc_clr) begin
      r_acc <= '0;
    end
  end

  assign acc_total = r_acc;
`endif

endmodule
`default_nettype wire
